tl_copy_engine: RTL and testbench
=================================

// Module: tl_copy_engine
// PURPOSE
//   TileLink-UL initiator that copies a block of 32-bit words from one address range
//   to another over a single tilelink_a / tilelink_d bus pair. Drives block_ram and
//   other TL-UL responders on the pinwheel bus.
//   Started by a one-cycle command pulse; reports busy / done / error to the host core.
//   Keeps one transaction outstanding at a time: Get (read), then PutFullData (write).
// PARAMETERS
//   TIMEOUT_CYCLES  16  max cycles in a WAIT state before abort with error (>=2)
//   COUNT_WIDTH     16  width of word_count and the internal remaining-word counter
// PORTS
//   clock       in   1            rising-edge clock (single clock domain)
//   reset_n     in   1            asynchronous, active-low reset
//   start       in   1            one-cycle command pulse, sampled only in IDLE
//   src_addr    in   32           source byte address; bits[1:0] forced to 0
//   dst_addr    in   32           destination byte address; bits[1:0] forced to 0
//   word_count  in   COUNT_WIDTH  number of 32-bit words to copy
//   busy        out  1            high from cycle after accepted start until DONE
//   done        out  1            one-cycle pulse at completion or abort
//   error       out  1            sticky abort flag; cleared by next accepted start
//   bus_tla     out  tilelink_a   A channel to the responder
//   bus_tld     in   tilelink_d   D channel from the responder
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE; busy=0, done=0, error=0; a_valid=0,
//     a_ready=1, all other A fields 0. Reset mid-copy abandons it; a late D beat is ignored.
//   Registered outputs. A beat accepted on an edge where a_valid && bus_tld.d_ready.
//     D beat consumed on an edge where d_valid; a_ready is held at 1 constantly.
//   A fields: a_size=2, a_mask=4'hF, a_source=0, a_param=0.
//     a_data = captured word on Put, 0 otherwise.
//   FSM:
//   - IDLE: start && word_count!=0 -> RD_REQ; latch addrs/count; clear error; busy=1.
//     start && word_count==0 -> DONE; no bus traffic; error=0.
//   - RD_REQ: a_valid=1, a_opcode=TL::Get, a_address=src. On accept -> RD_WAIT.
//   - RD_WAIT: a_valid=0. On d_valid: d_error=1 -> DONE with error=1.
//     Otherwise capture d_data; -> WR_REQ.
//   - WR_REQ: a_valid=1, a_opcode=TL::PutFullData, a_address=dst, a_data=captured.
//     On accept -> WR_WAIT.
//   - WR_WAIT: on d_valid: d_error -> DONE with error=1. Else src+=4, dst+=4, count-=1.
//     If count was 1 -> DONE, else -> RD_REQ.
//   - DONE: done=1 for exactly one cycle, busy=0; -> IDLE.
//   Responses: D opcode AccessAck or AccessAckData both accepted on writes;
//     d_data ignored on writes.
//   d_valid outside RD_WAIT/WR_WAIT is ignored, with no state change.
//   Timeout: cycle counter cleared on WAIT entry, increments each WAIT cycle.
//     Reaching TIMEOUT_CYCLES without d_valid -> DONE with error=1.
//   Addresses wrap modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000); no range check.
//   start while busy or in DONE is ignored, with no effect on latched values.
//   Throughput with a 1-cycle responder (d_ready=1): 4 cycles per word.
//     done pulses 4*N+1 cycles after the start edge.
// TESTING
//   1. block_ram preloaded; src=0x0,dst=0x100,count=4 -> RAM[0x40..0x43]==RAM[0..3];
//      done at cycle 17; error=0.
//   2. count=0 -> done pulse on cycle after start, a_valid never 1, busy stays 0.
//   3. Responder returns d_error=1 on 2nd Get -> exactly 1 word written, done+error=1.
//      Next start clears error.
//   4. Responder never answers -> done+error after TIMEOUT_CYCLES=16 WAIT cycles.
//   5. d_ready held 0 for 3 cycles in RD_REQ -> a_valid/a_address stable, no state advance.
//      Then the copy completes normally.
//   6. reset_n low mid-WR_WAIT -> a_valid=0, busy=0 immediately.
//      A stray d_valid after release is ignored; a new copy succeeds.
//   7. src=0xFFFFFFFC, count=2 -> second Get addresses 0x00000000.

Source files
------------

// File: rtl/tl_copy_engine.sv
// TileLink-UL block copy initiator: one Get, then one PutFullData per word,
// with a single transaction outstanding, a per-WAIT timeout and a sticky error flag.

package TL;
  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } d_op_e;

  typedef struct packed {
    logic        a_valid;
    a_op_e       a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_ready;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    d_op_e       d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        d_ready;
  } tilelink_d;
endpackage

module tl_copy_engine #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [31:0]            src_addr,
  input  logic [31:0]            dst_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output TL::tilelink_a          bus_tla,
  input  TL::tilelink_d          bus_tld,
  output logic [2:0]             fsm_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e                 state;
  logic [31:0]            src;
  logic [31:0]            dst;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [TW-1:0]          tcnt;
  logic                   timed_out;

  // Handshakes: an A beat transfers on a clock edge where a_valid and
  // bus_tld.d_ready are both 1; a D beat transfers on any edge with d_valid,
  // because a_ready is held at 1. Only one A beat is outstanding at a time.
  assign fsm_state = state;
  assign timed_out = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  logic unused_inputs;
  assign unused_inputs = ^{bus_tld.d_opcode, bus_tld.d_param, bus_tld.d_size,
                           bus_tld.d_source, src_addr[1:0], dst_addr[1:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      bus_tla           <= '0;
      bus_tla.a_ready   <= 1'b1;
      src               <= '0;
      dst               <= '0;
      remaining         <= '0;
      tcnt              <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error <= 1'b0;
            if (word_count != '0) begin
              src               <= {src_addr[31:2], 2'b00};
              dst               <= {dst_addr[31:2], 2'b00};
              remaining         <= word_count;
              busy              <= 1'b1;
              state             <= RD_REQ;
              bus_tla.a_valid   <= 1'b1;
              bus_tla.a_opcode  <= TL::Get;
              bus_tla.a_address <= {src_addr[31:2], 2'b00};
              bus_tla.a_data    <= '0;
              bus_tla.a_size    <= 3'd2;
              bus_tla.a_mask    <= 4'hF;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (bus_tld.d_ready) begin
            bus_tla.a_valid <= 1'b0;
            tcnt            <= '0;
            state           <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus_tld.d_valid) begin
            if (bus_tld.d_error) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state             <= WR_REQ;
              bus_tla.a_valid   <= 1'b1;
              bus_tla.a_opcode  <= TL::PutFullData;
              bus_tla.a_address <= dst;
              bus_tla.a_data    <= bus_tld.d_data;
            end
          end else if (timed_out) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WR_REQ: begin
          if (bus_tld.d_ready) begin
            bus_tla.a_valid <= 1'b0;
            bus_tla.a_data  <= '0;
            tcnt            <= '0;
            state           <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (bus_tld.d_valid) begin
            if (bus_tld.d_error) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              src       <= src + 32'd4;
              dst       <= dst + 32'd4;
              remaining <= remaining - 1'b1;
              if (remaining == COUNT_WIDTH'(1)) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state             <= RD_REQ;
                bus_tla.a_valid   <= 1'b1;
                bus_tla.a_opcode  <= TL::Get;
                bus_tla.a_address <= src + 32'd4;
              end
            end
          end else if (timed_out) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_copy_engine.sv
// Bench for tl_copy_engine: a block_ram responder model, an expected-beat and
// expected-completion scoreboard, and directed copy scenarios.

module tb_tl_copy_engine;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd4;

  logic          clock      = 1'b0;
  logic          reset_n    = 1'b0;
  logic          start      = 1'b0;
  logic [31:0]   src_addr   = '0;
  logic [31:0]   dst_addr   = '0;
  logic [15:0]   word_count = '0;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    fsm_state;
  TL::tilelink_a bus_tla;
  TL::tilelink_d bus_tld;

  // responder state
  logic          rsp_valid   = 1'b0;
  logic          rsp_err     = 1'b0;
  TL::d_op_e     rsp_op      = TL::AccessAck;
  logic [31:0]   rsp_data    = '0;
  logic          d_ready_drv = 1'b1;
  logic          stray       = 1'b0;
  logic          mute_all    = 1'b0;
  logic          mute_put    = 1'b0;
  int            err_on_get  = 0;
  int            get_cnt     = 0;
  logic [31:0]   mem [0:255];

  // scoreboard state
  logic [66:0]   exp_a_q [$];
  logic [16:0]   exp_d_q [$];
  int            total       = 0;
  int            bad         = 0;
  int            cyc         = 0;
  int            start_cyc   = 0;
  bit            seen_avalid = 1'b0;
  bit            seen_busy   = 1'b0;

  tl_copy_engine dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bus_tla    (bus_tla),
    .bus_tld    (bus_tld),
    .fsm_state  (fsm_state)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pre(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {b, 8'h5A, ~b, 8'hA5};
  endfunction

  always_comb begin
    bus_tld          = '0;
    bus_tld.d_valid  = rsp_valid | stray;
    bus_tld.d_opcode = rsp_op;
    bus_tld.d_size   = 3'd2;
    bus_tld.d_data   = rsp_data;
    bus_tld.d_error  = rsp_err;
    bus_tld.d_ready  = d_ready_drv;
  end

  // block_ram responder: answers each accepted A beat on the following cycle
  always @(posedge clock) begin
    rsp_valid <= 1'b0;
    rsp_err   <= 1'b0;
    rsp_data  <= '0;
    if (bus_tla.a_valid && d_ready_drv) begin
      if (bus_tla.a_opcode == TL::Get) begin
        get_cnt   <= get_cnt + 1;
        rsp_op    <= TL::AccessAckData;
        rsp_data  <= mem[bus_tla.a_address[9:2]];
        rsp_valid <= !mute_all;
        rsp_err   <= (get_cnt + 1 == err_on_get);
      end else begin
        mem[bus_tla.a_address[9:2]] <= bus_tla.a_data;
        rsp_op    <= TL::AccessAck;
        rsp_valid <= !(mute_all || mute_put);
      end
    end
  end

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_get(input logic [31:0] a);
    exp_a_q.push_back({TL::Get, a, 32'h0});
  endtask

  task automatic push_put(input logic [31:0] a, input logic [31:0] d);
    exp_a_q.push_back({TL::PutFullData, a, d});
  endtask

  task automatic push_done(input logic err, input int cycles);
    exp_d_q.push_back({err, 16'(cycles)});
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a beat or a completion
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus_tla.a_valid) seen_avalid = 1'b1;
      if (busy) seen_busy = 1'b1;
      if (bus_tla.a_valid && bus_tld.d_ready) begin
        if (exp_a_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_beat_unexpected: actual=%0h required=none",
                   {bus_tla.a_opcode, bus_tla.a_address, bus_tla.a_data});
        end else begin
          check("a_beat", {bus_tla.a_opcode, bus_tla.a_address, bus_tla.a_data},
                exp_a_q.pop_front());
        end
      end
      if (done) begin
        if (exp_d_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: actual error=%0b required=none", error);
        end else begin
          check("done_err_cycles", {error, 16'(cyc - start_cyc)}, exp_d_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(posedge clock);
    #1;
    src_addr   = s;
    dst_addr   = d;
    word_count = n;
    start      = 1'b1;
    start_cyc  = cyc;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s: actual=no done pulse required=done within 300 cycles", name);
    end
    @(negedge clock);
    check({name, "_pulse_width"}, {done, fsm_state}, {1'b0, S_IDLE});
  endtask

  initial begin
    TL::tilelink_a rst_a;
    bit found;
    for (int i = 0; i < 256; i++) mem[i] <= pre(i);

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    rst_a         = '0;
    rst_a.a_ready = 1'b1;
    check("reset_flags", {busy, done, error, fsm_state}, {3'b000, S_IDLE});
    check("reset_bus_a", bus_tla, rst_a);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // 4-word copy 0x0 -> 0x100
    for (int i = 0; i < 4; i++) begin
      push_get(32'(i * 4));
      push_put(32'h100 + 32'(i * 4), pre(i));
    end
    push_done(1'b0, 17);
    do_start(32'h0, 32'h100, 16'd4);
    @(negedge clock);
    check("busy_after_start", {busy, fsm_state}, {1'b1, S_RD_REQ});
    check("a_static_fields",
          {bus_tla.a_size, bus_tla.a_mask, bus_tla.a_source, bus_tla.a_param, bus_tla.a_ready},
          {3'd2, 4'hF, 4'h0, 3'd0, 1'b1});
    wait_done("copy4");
    for (int i = 0; i < 4; i++) check("copy4_ram", mem[64 + i], pre(i));

    // zero-length command
    seen_avalid = 1'b0;
    seen_busy   = 1'b0;
    push_done(1'b0, 1);
    do_start(32'h10, 32'h110, 16'd0);
    wait_done("count0");
    check("count0_no_traffic", {seen_avalid, seen_busy}, 2'b00);

    // error on the second Get
    err_on_get = get_cnt + 2;
    push_get(32'h20);
    push_put(32'h180, pre(8));
    push_get(32'h24);
    push_done(1'b1, 7);
    do_start(32'h20, 32'h180, 16'd3);
    wait_done("derr");
    err_on_get = 0;
    check("derr_sticky", error, 1'b1);
    check("derr_word0", mem[96], pre(8));
    check("derr_word1_untouched", mem[97], pre(97));

    // next start clears the error
    push_get(32'h30);
    push_put(32'h1C0, pre(12));
    push_done(1'b0, 5);
    do_start(32'h30, 32'h1C0, 16'd1);
    @(negedge clock);
    check("error_cleared", {busy, error}, 2'b10);
    wait_done("after_err");
    check("after_err_ram", mem[112], pre(12));

    // responder never answers
    mute_all = 1'b1;
    push_get(32'h70);
    push_done(1'b1, 18);
    do_start(32'h70, 32'h170, 16'd2);
    wait_done("timeout");
    mute_all = 1'b0;

    // A-channel back-pressure for 3 cycles in RD_REQ
    d_ready_drv = 1'b0;
    push_get(32'h40);
    push_put(32'h140, pre(16));
    push_get(32'h44);
    push_put(32'h144, pre(17));
    push_done(1'b0, 12);
    do_start(32'h40, 32'h140, 16'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_hold", {bus_tla.a_valid, bus_tla.a_address, fsm_state},
            {1'b1, 32'h40, S_RD_REQ});
      @(posedge clock);
      #1;
    end
    d_ready_drv = 1'b1;
    wait_done("stall");
    check("stall_ram", {mem[80], mem[81]}, {pre(16), pre(17)});

    // reset in WR_WAIT, stray D beat, then a clean copy
    mute_put = 1'b1;
    push_get(32'h50);
    push_put(32'h300, pre(20));
    do_start(32'h50, 32'h300, 16'd1);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (fsm_state == S_WR_WAIT) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_wr_wait", found, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", {bus_tla.a_valid, busy, fsm_state}, {2'b00, S_IDLE});
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    mute_put = 1'b0;
    @(posedge clock);
    #1 stray = 1'b1;
    @(posedge clock);
    #1 stray = 1'b0;
    @(negedge clock);
    check("stray_ignored", {fsm_state, busy, done, bus_tla.a_valid}, {S_IDLE, 3'b000});
    push_get(32'h60);
    push_put(32'h340, pre(24));
    push_done(1'b0, 5);
    do_start(32'h60, 32'h340, 16'd1);
    wait_done("post_reset");
    check("post_reset_ram", mem[208], pre(24));

    // source address wraps past 0xFFFFFFFC
    push_get(32'hFFFF_FFFC);
    push_put(32'h200, pre(255));
    push_get(32'h0);
    push_put(32'h204, pre(0));
    push_done(1'b0, 9);
    do_start(32'hFFFF_FFFC, 32'h200, 16'd2);
    wait_done("wrap");
    check("wrap_ram", {mem[128], mem[129]}, {pre(255), pre(0)});

    // final report
    repeat (2) @(negedge clock);
    check("exp_a_q_empty", exp_a_q.size(), 0);
    check("exp_d_q_empty", exp_d_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
